jam_gen: RTL and testbench

JAM_GEN -- requirements
Module: jam_gen

---
 rtl/jam_gen.sv | 193 +++++++++++++++++++
 tb/tb_jam_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jam_gen.sv
// Exhaustive assignment search: walks all N! permutations, summing ROM costs and tracking min/tie count.
// Optional macro JAM_BEST_PERM_EN compiles in the first-minimal-permutation capture register (BestPerm).
`timescale 1ns/1ps
module jam_gen #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int SW = CW + 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic [2:0]    W,
  output logic [2:0]    J,
  input  logic [CW-1:0] Cost,
  output logic [SW-1:0] MinCost,
  output logic [15:0]   MatchCount,
  output logic [23:0]   BestPerm,
  output logic          Valid,
  output logic          Busy
);

  typedef enum logic [1:0] {IDLE, LOAD, NEXT, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] min_q, min_d;
  logic [SW-1:0] total;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    perm_q [8];
  logic [2:0]    perm_d [8];
  logic [2:0]    ident [8];
  logic [2:0]    swp_arr [8];
  logic [2:0]    succ [8];
  logic [2:0]    piv, swp;
  logic          has_asc;
  logic          last_k;

  // Arrays are sized 8 so a 3-bit index is always exact; entries at and above N stay 0.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      ident[k] = (k < N) ? 3'(k) : 3'd0;
    end
  end

  assign last_k = (k_q == 3'(N - 1));
  assign total  = sum_q + SW'(Cost);

  // Lexicographic successor; has_asc==0 means perm_q is the final (descending) permutation.
  always_comb begin
    has_asc = 1'b0;
    piv     = '0;
    swp     = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        has_asc = 1'b1;
        piv     = 3'(i);
      end
    end
    for (int j = 0; j < N; j++) begin
      if ((3'(j) > piv) && (perm_q[j] > perm_q[piv])) begin
        swp = 3'(j);
      end
    end
    for (int k = 0; k < 8; k++) begin
      swp_arr[k] = perm_q[k];
    end
    swp_arr[piv] = perm_q[swp];
    swp_arr[swp] = perm_q[piv];
    for (int k = 0; k < 8; k++) begin
      if ((k > int'(piv)) && (k < N)) begin
        succ[k] = swp_arr[3'(N + int'(piv) - k)];
      end else begin
        succ[k] = swp_arr[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = LOAD;
      LOAD:    if (last_k) state_d = has_asc ? NEXT : DONE;
      NEXT:    state_d = LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef JAM_BEST_PERM_EN
  logic [2:0]  best_q [8];
  logic [2:0]  best_d [8];
  logic [23:0] best_vec;
`endif

  always_comb begin
    k_d    = k_q;
    sum_d  = sum_q;
    min_d  = min_q;
    cnt_d  = cnt_q;
    perm_d = perm_q;
`ifdef JAM_BEST_PERM_EN
    best_d = best_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          k_d    = '0;
          sum_d  = '0;
          min_d  = '1;
          cnt_d  = '0;
          perm_d = ident;
`ifdef JAM_BEST_PERM_EN
          for (int k = 0; k < 8; k++) best_d[k] = 3'd0;
`endif
        end
      end
      LOAD: begin
        sum_d = total;
        k_d   = k_q + 3'd1;
        if (last_k) begin
          k_d   = '0;
          sum_d = '0;
          if (total < min_q) begin
            min_d = total;
            cnt_d = 16'd1;
`ifdef JAM_BEST_PERM_EN
            best_d = perm_q;
`endif
          end else if (total == min_q) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      NEXT: begin
        perm_d = succ;
        sum_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      k_q     <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
      for (int k = 0; k < 8; k++) perm_q[k] <= (k < N) ? 3'(k) : 3'd0;
`ifdef JAM_BEST_PERM_EN
      for (int k = 0; k < 8; k++) best_q[k] <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      perm_q  <= perm_d;
`ifdef JAM_BEST_PERM_EN
      best_q  <= best_d;
`endif
    end
  end

  always_comb begin
    W = '0;
    J = '0;
    if (state_q == LOAD) begin
      W = k_q;
      J = perm_q[k_q];
    end
    Valid = (state_q == DONE);
    Busy  = (state_q != IDLE);
  end

  assign MinCost    = min_q;
  assign MatchCount = cnt_q;

`ifdef JAM_BEST_PERM_EN
  always_comb begin
    best_vec = '0;
    for (int w = 0; w < N; w++) begin
      best_vec[3*w +: 3] = best_q[w];
    end
  end
  assign BestPerm = best_vec;
`else
  assign BestPerm = '0;
`endif

endmodule

// File: tb/tb_jam_gen.sv
// Directed bench for jam_gen at N=4: cost patterns with hand-derived min/tie/first-permutation results and run timing.
`timescale 1ns/1ps
module tb_jam_gen;
  localparam int N  = 4;
  localparam int CW = 7;
  localparam int SW = 10;
  localparam int RUN_EDGES = 119; // 4! * 5 - 1

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          START;
  logic [2:0]    W, J;
  logic [CW-1:0] Cost;
  logic [SW-1:0] MinCost;
  logic [15:0]   MatchCount;
  logic [23:0]   BestPerm;
  logic          Valid, Busy;

  int mode;
  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;
  int vcount   = 0;
  int v0;

  jam_gen #(.N(N), .CW(CW), .SW(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .BestPerm(BestPerm),
    .Valid(Valid), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Valid) vcount++;

  // Cost ROM model, combinational on W/J.
  always_comb begin
    case (mode)
      0:       Cost = (J == W) ? 7'd1 : 7'd10;
      1:       Cost = (J == 3'd3 - W) ? 7'd0 : 7'd5;
      2:       Cost = 7'd5;
      3:       Cost = 7'd127;
      default: Cost = (W == 3'd0 && J == 3'd3) ? 7'd1 : 7'd2;
    endcase
  end

  function automatic logic [23:0] bp(input logic [2:0] j0, input logic [2:0] j1,
                                     input logic [2:0] j2, input logic [2:0] j3);
    logic [23:0] v;
    v = {12'd0, j3, j2, j1, j0};
`ifndef JAM_BEST_PERM_EN
    v = '0;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step_to(input int target);
    while (edges < target) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_valid(input int limit);
    while (!Valid && edges < limit) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
  endtask

  task automatic start_run(input int m);
    @(negedge CLK);
    mode  = m;
    START = 1'b1;
    @(posedge CLK);
    edges = 0;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int min, input int cnt, input logic [23:0] best);
    wait_valid(1000);
    check({tag, "_edge"}, edges, RUN_EDGES);
    check({tag, "_valid"}, 32'(Valid), 1);
    check({tag, "_min"}, 32'(MinCost), min);
    check({tag, "_cnt"}, 32'(MatchCount), cnt);
    check({tag, "_best"}, 32'(BestPerm), 32'(best));
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_valid_drop"}, 32'(Valid), 0);
    check({tag, "_idle"}, 32'(Busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    mode  = 0;
    #12;
    check("rst_busy", 32'(Busy), 0);
    check("rst_valid", 32'(Valid), 0);
    check("rst_w", 32'(W), 0);
    check("rst_j", 32'(J), 0);
    check("rst_min", 32'(MinCost), 1023);
    check("rst_cnt", 32'(MatchCount), 0);
    check("rst_best", 32'(BestPerm), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_start", 32'(Busy), 0);

    // Diagonal costs, with a look inside the run.
    start_run(0);
    check("load0_w", 32'(W), 0);
    check("load0_j", 32'(J), 0);
    check("load0_busy", 32'(Busy), 1);
    step_to(4);
    check("next_w", 32'(W), 0);
    check("next_j", 32'(J), 0);
    check("next_busy", 32'(Busy), 1);
    check("next_valid", 32'(Valid), 0);
    check("first_min", 32'(MinCost), 4);
    check("first_cnt", 32'(MatchCount), 1);
    step_to(8);
    check("perm2_w", 32'(W), 3);
    check("perm2_j", 32'(J), 2);
    finish_run("diag", 4, 1, bp(0, 1, 2, 3));

    // Results hold in IDLE even when the ROM contents change.
    mode = 2;
    repeat (5) @(negedge CLK);
    check("hold_min", 32'(MinCost), 4);
    check("hold_cnt", 32'(MatchCount), 1);
    check("hold_best", 32'(BestPerm), 32'(bp(0, 1, 2, 3)));
    check("hold_w", 32'(W), 0);
    check("hold_j", 32'(J), 0);

    start_run(2);
    finish_run("const5", 20, 24, bp(0, 1, 2, 3));
    start_run(3);
    finish_run("const127", 508, 24, bp(0, 1, 2, 3));
    start_run(1);
    finish_run("anti", 0, 1, bp(3, 2, 1, 0));
    start_run(4);
    finish_run("tie", 7, 6, bp(3, 0, 1, 2));

    // Abort mid-LOAD with reset, then a clean rerun.
    v0 = vcount;
    start_run(2);
    step_to(7);
    #2 RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 0);
    check("abort_valid", 32'(Valid), 0);
    check("abort_w", 32'(W), 0);
    check("abort_j", 32'(J), 0);
    check("abort_min", 32'(MinCost), 1023);
    check("abort_cnt", 32'(MatchCount), 0);
    check("abort_best", 32'(BestPerm), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("abort_stay_idle", 32'(Busy), 0);
    check("abort_no_valid", 32'(vcount - v0), 0);
    start_run(2);
    finish_run("rerun", 20, 24, bp(0, 1, 2, 3));
    check("rerun_pulses", 32'(vcount - v0), 1);

    // START held high across two back-to-back runs.
    v0 = vcount;
    @(negedge CLK);
    mode  = 0;
    START = 1'b1;
    @(posedge CLK);
    edges = 0;
    @(negedge CLK);
    wait_valid(1000);
    check("held_edge1", edges, RUN_EDGES);
    step_to(RUN_EDGES + 1);
    check("held_gap_busy", 32'(Busy), 0);
    check("held_gap_valid", 32'(Valid), 0);
    wait_valid(1000);
    check("held_edge2", edges, 2 * RUN_EDGES + 2);
    check("held_min", 32'(MinCost), 4);
    START = 1'b0;
    step_to(edges + 3);
    check("held_end_idle", 32'(Busy), 0);
    check("held_pulses", 32'(vcount - v0), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
